// File: rtl/divmod_pkg.sv
// =============================================================================
// divmod_pkg : shared types and constants for the multi-cycle divider
// Rev 1.0
// =============================================================================
`default_nettype none

package divmod_pkg;

    localparam int DIVMOD_WIDTH     = 16;
    localparam int DIVMOD_STEP_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int iter_count(input int width, input int step_bits);
        return width / step_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/divmod_if.sv
// =============================================================================
// divmod_if : request/result bundle between a client and the divider
// Rev 1.0
// =============================================================================
`default_nettype none

interface divmod_if
    import divmod_pkg::*;
#(
    parameter int WIDTH = DIVMOD_WIDTH
);
    logic             go;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic             ready;
    logic             error;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    modport master (
        output go, num, den,
        input  ready, error, quot, rem
    );

    modport slave (
        input  go, num, den,
        output ready, error, quot, rem
    );
endinterface

`default_nettype wire

// File: rtl/divmod_step.sv
// =============================================================================
// divmod_step : one combinational restoring-division step (one quotient bit)
// Rev 1.0
// =============================================================================
`default_nettype none

module divmod_step
    import divmod_pkg::*;
#(
    parameter int WIDTH = DIVMOD_WIDTH
) (
    input  logic [WIDTH:0]   r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH:0]   r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;

    // The borrow out of the extra top bit doubles as the R >= den compare.
    assign w_shift = {r_in, q_in[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, den};
    assign w_ge    = ~w_diff[WIDTH+1];

    assign r_out = w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    assign q_out = {q_in[WIDTH-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/divmod.sv
// =============================================================================
// divmod : multi-cycle unsigned divider, STEP_BITS quotient bits per cycle
// Rev 1.0
// =============================================================================
`default_nettype none

module divmod
    import divmod_pkg::*;
#(
    parameter int WIDTH     = DIVMOD_WIDTH,
    parameter int STEP_BITS = DIVMOD_STEP_BITS
) (
    input  logic     clk,
    input  logic     rst,
    divmod_if.slave  bus
);

    localparam int ITER  = iter_count(WIDTH, STEP_BITS);
    localparam int CNT_W = $clog2(ITER + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_error;

    logic             w_accept;
    logic             w_iter_done;
    logic [WIDTH:0]   w_r [STEP_BITS+1];
    logic [WIDTH-1:0] w_q [STEP_BITS+1];

    assign w_accept    = bus.go && (r_state != BUSY);
    assign w_iter_done = (r_cnt == '0);

    assign w_r[0] = r_r;
    assign w_q[0] = r_q;

    generate
        for (genvar gi = 0; gi < STEP_BITS; gi++) begin : g_step
            divmod_step #(.WIDTH(WIDTH)) u_step (
                .r_in  (w_r[gi]),
                .q_in  (w_q[gi]),
                .den   (r_den),
                .r_out (w_r[gi+1]),
                .q_out (w_q[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (bus.go) begin
                    w_next_state = (bus.den == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_iter_done) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (r_state == DONE);
        bus.error = r_error;
        bus.quot  = r_quot;
        bus.rem   = r_rem;
    end

    // Zero divisor bypasses iteration and lands results directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_den   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_den <= bus.den;
            r_q   <= bus.num;
            r_r   <= '0;
            r_cnt <= CNT_W'(ITER);
            if (bus.den == '0) begin
                r_error <= 1'b1;
                r_quot  <= '1;
                r_rem   <= bus.num;
            end else begin
                r_error <= 1'b0;
            end
        end else if (r_state == BUSY) begin
            if (w_iter_done) begin
                r_quot <= r_q;
                r_rem  <= r_r[WIDTH-1:0];
            end else begin
                r_q   <= w_q[STEP_BITS];
                r_r   <= w_r[STEP_BITS];
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divmod.sv
// =============================================================================
// tb_divmod : scoreboard-driven self-checking bench for divmod
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_divmod;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         error;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   vectors;
    int   miscompares;

    divmod_if #(.WIDTH(W)) bus ();

    divmod #(.WIDTH(W), .STEP_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_exp(input logic [W-1:0] n, input logic [W-1:0] d);
        exp_t e;
        e.num = n;
        e.den = d;
        if (d == '0) begin
            e.quot  = '1;
            e.rem   = n;
            e.error = 1'b1;
        end else begin
            e.quot  = n / d;
            e.rem   = n % d;
            e.error = 1'b0;
        end
        sb.push_back(e);
    endfunction

    // Pulse go, scramble operands while busy, then wait (bounded) for ready.
    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic e, output int cyc, output bit tmo);
        @(negedge clk);
        bus.go = 1'b1; bus.num = n; bus.den = d;
        @(negedge clk);
        bus.go = 1'b0; bus.num = W'($urandom); bus.den = W'($urandom);
        cyc = 1;
        tmo = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.ready === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        q = bus.quot;
        r = bus.rem;
        e = bus.error;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.go = 1'b1; bus.num = 16'd9; bus.den = 16'd2;
        repeat (2) @(negedge clk);
        vectors += 4;
        if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
        if (bus.error !== 1'b0) begin miscompares++; $display("FAIL reset_error got=%b want=0", bus.error); end
        if (bus.quot !== 16'd0) begin miscompares++; $display("FAIL reset_quot got=%h want=0000", bus.quot); end
        if (bus.rem !== 16'd0)  begin miscompares++; $display("FAIL reset_rem got=%h want=0000", bus.rem); end
        bus.go = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL idle_ready got=%b want=0", bus.ready); end
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r; logic e; int cyc; bit tmo; exp_t x;
        push_exp(16'd17, 16'd5);
        run_op(16'd17, 16'd5, q, r, e, cyc, tmo);
        x = sb.pop_front();
        vectors += 2;
        if (tmo || cyc > 9) begin miscompares++; $display("FAIL basic_latency cycles=%0d timeout=%0d want<=9", cyc, tmo); end
        if ({e, q, r} !== {x.error, x.quot, x.rem}) begin
            miscompares++;
            $display("FAIL basic 17/5 got q=%h r=%h e=%b want q=%h r=%h e=%b", q, r, e, x.quot, x.rem, x.error);
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r; logic e; int cyc; bit tmo; exp_t x;
        push_exp(16'd7, 16'd0);
        run_op(16'd7, 16'd0, q, r, e, cyc, tmo);
        x = sb.pop_front();
        vectors += 2;
        if (tmo || cyc > 9) begin miscompares++; $display("FAIL divzero_latency cycles=%0d timeout=%0d want<=9", cyc, tmo); end
        if ({e, q, r} !== {x.error, x.quot, x.rem}) begin
            miscompares++;
            $display("FAIL divzero 7/0 got q=%h r=%h e=%b want q=%h r=%h e=%b", q, r, e, x.quot, x.rem, x.error);
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] q, r; logic e; int cyc; bit tmo; exp_t x;
        for (int n = 0; n < 20; n++) begin
            for (int d = 1; d < 20; d++) begin
                push_exp(W'(n), W'(d));
                run_op(W'(n), W'(d), q, r, e, cyc, tmo);
                x = sb.pop_front();
                vectors++;
                if (tmo || {e, q, r} !== {x.error, x.quot, x.rem}) begin
                    miscompares++;
                    $display("FAIL sweep %0d/%0d got q=%h r=%h e=%b tmo=%0d want q=%h r=%h e=%b",
                             n, d, q, r, e, tmo, x.quot, x.rem, x.error);
                end
            end
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] q, r; logic e; int cyc; bit tmo; exp_t x;
        logic [W-1:0] ns [8];
        logic [W-1:0] ds [8];
        ns = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'd3, 16'hFFFE, 16'h8000, 16'd12345, 16'hFFFF};
        ds = '{16'h0001, 16'hFFFF, 16'd5,    16'd9, 16'hFFFF, 16'h0003, 16'd77,    16'h0000};
        for (int i = 0; i < 8; i++) begin
            push_exp(ns[i], ds[i]);
            run_op(ns[i], ds[i], q, r, e, cyc, tmo);
            x = sb.pop_front();
            vectors++;
            if (tmo || {e, q, r} !== {x.error, x.quot, x.rem}) begin
                miscompares++;
                $display("FAIL extreme %h/%h got q=%h r=%h e=%b tmo=%0d want q=%h r=%h e=%b",
                         ns[i], ds[i], q, r, e, tmo, x.quot, x.rem, x.error);
            end
        end
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] n, d;
            n = W'($urandom);
            d = W'($urandom_range(1, 300));
            push_exp(n, d);
            run_op(n, d, q, r, e, cyc, tmo);
            x = sb.pop_front();
            vectors++;
            if (tmo || {e, q, r} !== {x.error, x.quot, x.rem}) begin
                miscompares++;
                $display("FAIL random %h/%h got q=%h r=%h e=%b want q=%h r=%h e=%b", n, d, q, r, e, x.quot, x.rem, x.error);
            end
        end
    endtask

    // A second go while busy must be ignored; results then hold while idle.
    task automatic test_busy_go_and_hold();
        exp_t x;
        bit   seen;
        push_exp(16'd200, 16'd9);
        @(negedge clk);
        bus.go = 1'b1; bus.num = 16'd200; bus.den = 16'd9;
        @(negedge clk);
        bus.num = 16'd50; bus.den = 16'd0;
        @(negedge clk);
        bus.go = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.ready === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        x = sb.pop_front();
        vectors++;
        if (!seen || {bus.error, bus.quot, bus.rem} !== {x.error, x.quot, x.rem}) begin
            miscompares++;
            $display("FAIL busy_go got q=%h r=%h e=%b ready=%b want q=%h r=%h e=%b",
                     bus.quot, bus.rem, bus.error, bus.ready, x.quot, x.rem, x.error);
        end
        bus.num = 16'd1; bus.den = 16'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.ready, bus.error, bus.quot, bus.rem} !== {1'b1, x.error, x.quot, x.rem}) begin
            miscompares++;
            $display("FAIL hold got ready=%b q=%h r=%h e=%b want ready=1 q=%h r=%h e=%b",
                     bus.ready, bus.quot, bus.rem, bus.error, x.quot, x.rem, x.error);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [W-1:0] q, r; logic e; int cyc; bit tmo; exp_t x;
        @(negedge clk);
        bus.go = 1'b1; bus.num = 16'd1000; bus.den = 16'd3;
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.ready, bus.error, bus.quot, bus.rem} !== {1'b0, 1'b0, 16'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL midreset got ready=%b e=%b q=%h r=%h want all zero", bus.ready, bus.error, bus.quot, bus.rem);
        end
        rst = 1'b1;
        push_exp(16'd100, 16'd7);
        run_op(16'd100, 16'd7, q, r, e, cyc, tmo);
        x = sb.pop_front();
        vectors++;
        if (tmo || {e, q, r} !== {x.error, x.quot, x.rem}) begin
            miscompares++;
            $display("FAIL after_midreset got q=%h r=%h e=%b want q=%h r=%h e=%b", q, r, e, x.quot, x.rem, x.error);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        bus.go      = 1'b0;
        bus.num     = '0;
        bus.den     = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_sweep();
        test_extremes();
        test_busy_go_and_hold();
        test_reset_mid_busy();
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
